// File: rtl/rgmii_link_ctrl.sv
// Autonomous MDIO (Clause 22) poller that reads the PHY status register,
// filters link/speed, and drives the RGMII speed select.
module rgmii_link_ctrl #(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter logic [4:0] STATUS_REG    = 5'd17,
    parameter int         LINK_BIT      = 10,
    parameter int         SPEED_BIT     = 14,
    parameter int         MDC_DIV       = 50,
    parameter int         POLL_INTERVAL = 125000,
    parameter int         STABLE_COUNT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [1:0]  speed,
    output logic        link_up,
    output logic [15:0] status,
    output logic        error,
    output logic        update,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_CMD      = 3'd2;
    localparam logic [2:0] ST_TA       = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam int DIV_W  = $clog2(2 * MDC_DIV);
    localparam int POLL_W = $clog2(POLL_INTERVAL + 1);
    localparam int STAB_W = $clog2(STABLE_COUNT + 1);

    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(MDC_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * MDC_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_COUNT);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

    // Start(01), read opcode(10), PHY address, register address; MSB first.
    localparam logic [13:0] CMD_WORD = {2'b01, 2'b10, PHY_ADDR, STATUS_REG};

    logic [2:0]        state;
    logic [4:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_armed;
    logic [13:0]       tx_sr;
    logic [15:0]       rx_sr;
    logic              no_phy;
    logic [STAB_W-1:0] stab_cnt;
    logic [1:0]        prev_speed;
    logic              mdio_s1;
    logic              mdio_s2;

    logic              bit_end;
    logic [1:0]        raw_field;
    logic [1:0]        raw_speed;
    logic              raw_link;
    logic [STAB_W-1:0] stab_next;
    logic              apply;
    logic [1:0]        speed_next;
    logic              link_next;

    assign bit_end   = (div_cnt == DIV_LAST);
    assign raw_field = rx_sr[SPEED_BIT+1:SPEED_BIT];
    assign raw_speed = (raw_field == 2'b11) ? 2'b10 : raw_field;
    assign raw_link  = rx_sr[LINK_BIT] & ~no_phy;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        stab_next = '0;
        if (raw_link) begin
            if (raw_speed != prev_speed) begin
                stab_next = STAB_ONE;
            end else if (stab_cnt == STAB_MAX) begin
                stab_next = stab_cnt;
            end else begin
                stab_next = stab_cnt + STAB_ONE;
            end
        end
    end

    assign apply      = raw_link && (stab_next == STAB_MAX);
    assign speed_next = apply ? raw_speed : speed;
    assign link_next  = raw_link && (apply || link_up);

    // The pad is idle-high (pulled up), so the synchronizer resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            poll_cnt   <= '0;
            poll_armed <= 1'b1;
            tx_sr      <= '0;
            rx_sr      <= '0;
            no_phy     <= 1'b0;
            stab_cnt   <= '0;
            prev_speed <= 2'b00;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_t     <= 1'b0;
            speed      <= 2'b10;
            link_up    <= 1'b0;
            status     <= '0;
            error      <= 1'b0;
            update     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && (poll_armed || poll_cnt == POLL_LAST)) begin
                        state      <= ST_PREAMBLE;
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        poll_cnt   <= '0;
                        poll_armed <= 1'b0;
                        busy       <= 1'b1;
                        mdc        <= 1'b0;
                        mdio_o     <= 1'b1;
                        mdio_t     <= 1'b1;
                    end else if (enable) begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                    end else begin
                        poll_cnt <= '0;
                    end
                end

                ST_PREAMBLE, ST_CMD, ST_TA, ST_DATA: begin
                    div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
                    if (div_cnt == DIV_HALF) begin
                        mdc <= 1'b1;
                    end
                    if (bit_end) begin
                        mdc     <= 1'b0;
                        bit_cnt <= bit_cnt + 5'd1;
                        case (state)
                            ST_PREAMBLE: begin
                                if (bit_cnt == 5'd31) begin
                                    state   <= ST_CMD;
                                    bit_cnt <= '0;
                                    mdio_o  <= CMD_WORD[13];
                                    tx_sr   <= {CMD_WORD[12:0], 1'b0};
                                end
                            end
                            ST_CMD: begin
                                if (bit_cnt == 5'd13) begin
                                    state   <= ST_TA;
                                    bit_cnt <= '0;
                                    mdio_o  <= 1'b1;
                                    mdio_t  <= 1'b0;
                                end else begin
                                    mdio_o <= tx_sr[13];
                                    tx_sr  <= {tx_sr[12:0], 1'b0};
                                end
                            end
                            ST_TA: begin
                                // A present PHY pulls the second turnaround bit low.
                                if (bit_cnt == 5'd1) begin
                                    no_phy  <= mdio_s2;
                                    state   <= ST_DATA;
                                    bit_cnt <= '0;
                                end
                            end
                            default: begin
                                rx_sr <= {rx_sr[14:0], mdio_s2};
                                if (bit_cnt == 5'd15) begin
                                    state <= ST_DONE;
                                end
                            end
                        endcase
                    end
                end

                ST_DONE: begin
                    status     <= rx_sr;
                    error      <= no_phy;
                    speed      <= speed_next;
                    link_up    <= link_next;
                    stab_cnt   <= stab_next;
                    prev_speed <= raw_speed;
                    update     <= (speed_next != speed) || (link_next != link_up);
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Directed bench for rgmii_link_ctrl: a small MDIO PHY model answers each
// read, and a linear sequence of steps checks framing, filtering and reset.
module tb_rgmii_link_ctrl;

    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic [1:0]  speed;
    logic        link_up;
    logic [15:0] status;
    logic        error;
    logic        update;
    logic        busy;

    logic        phy_present;
    logic [15:0] phy_word;

    int total = 0;
    int bad   = 0;

    rgmii_link_ctrl #(
        .PHY_ADDR      (5'd0),
        .STATUS_REG    (5'd17),
        .LINK_BIT      (10),
        .SPEED_BIT     (14),
        .MDC_DIV       (4),
        .POLL_INTERVAL (20),
        .STABLE_COUNT  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mdc     (mdc),
        .mdio_i  (mdio_i),
        .mdio_o  (mdio_o),
        .mdio_t  (mdio_t),
        .speed   (speed),
        .link_up (link_up),
        .status  (status),
        .error   (error),
        .update  (update),
        .busy    (busy)
    );

    always #4 clk = ~clk;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    // PHY model: drives a new bit after each mdc rising edge; TA bit 2 low, then data MSB first.
    initial begin : phy_model
        logic [15:0] sr;
        sr     = '0;
        mdio_i = 1'b1;
        forever begin
            @(posedge busy);
            for (int b = 0; b < 64; b++) begin
                @(posedge mdc or negedge busy);
                if (!busy) break;
                if (phy_present && b == 47) begin
                    mdio_i = 1'b0;
                    sr     = phy_word;
                end else if (phy_present && b >= 48) begin
                    mdio_i = sr[15];
                    sr     = {sr[14:0], 1'b0};
                end else begin
                    mdio_i = 1'b1;
                end
            end
            if (busy) @(negedge busy);
            mdio_i = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a frame to start (if idle) and finish; returns update seen in the DONE+1 cycle.
    task automatic wait_done(output logic upd);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_in_time", 32'(n < LIMIT), 1);
        n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("frame_end_in_time", 32'(n < LIMIT), 1);
        upd = update;
    endtask

    initial begin : stimulus
        logic        upd;
        int          t_cnt;
        int          pre_ones;
        int          busy_cnt;
        int          n;
        logic [13:0] cmd;

        rst         = 1'b1;
        enable      = 1'b1;
        phy_present = 1'b1;
        phy_word    = 16'hA400;
        repeat (3) @(negedge clk);

        check("rst_mdc",     32'(mdc),     0);
        check("rst_mdio_o",  32'(mdio_o),  1);
        check("rst_mdio_t",  32'(mdio_t),  0);
        check("rst_speed",   32'(speed),   2);
        check("rst_link_up", 32'(link_up), 0);
        check("rst_status",  32'(status),  0);
        check("rst_error",   32'(error),   0);
        check("rst_update",  32'(update),  0);
        check("rst_busy",    32'(busy),    0);

        // First frame must start on the cycle after reset release.
        rst = 1'b0;
        @(negedge clk);
        check("start_busy",   32'(busy),   1);
        check("start_mdc",    32'(mdc),    0);
        check("start_mdio_t", 32'(mdio_t), 1);

        t_cnt    = 0;
        pre_ones = 0;
        cmd      = '0;
        for (int c = 0; c < 400; c++) begin
            if (mdio_t) t_cnt++;
            if (c % 8 == 0 && c / 8 < 32 && mdio_o) pre_ones++;
            if (c % 8 == 0 && c / 8 >= 32 && c / 8 < 46) cmd = {cmd[12:0], mdio_o};
            if (c == 4) check("mdc_high_half", 32'(mdc), 1);
            @(negedge clk);
        end
        check("mdio_t_cycles", 32'(t_cnt), 368);
        check("preamble_ones", 32'(pre_ones), 32);
        check("cmd_bits", 32'(cmd), 32'b01_10_00000_10001);

        // Stable 1000M link: link comes up after the third identical read.
        wait_done(upd);
        check("f1_link_up", 32'(link_up), 0);
        check("f1_status",  32'(status),  16'hA400);
        check("f1_error",   32'(error),   0);
        check("f1_update",  32'(upd),     0);
        wait_done(upd);
        check("f2_link_up", 32'(link_up), 0);
        wait_done(upd);
        check("f3_link_up", 32'(link_up), 1);
        check("f3_speed",   32'(speed),   2);
        check("f3_update",  32'(upd),     1);
        check("f3_status",  32'(status),  16'hA400);

        // A single link-down read drops the link immediately.
        phy_word = 16'h0000;
        wait_done(upd);
        check("down_link_up", 32'(link_up), 0);
        check("down_speed",   32'(speed),   2);
        check("down_update",  32'(upd),     1);
        check("down_status",  32'(status),  16'h0000);

        // Alternating speed fields never satisfy the filter.
        for (int i = 0; i < 4; i++) begin
            phy_word = (i % 2 == 0) ? 16'h4400 : 16'h0400;
            wait_done(upd);
            check("alt_link_up", 32'(link_up), 0);
            check("alt_speed",   32'(speed),   2);
        end

        // Five reads at 100M: applied on the third.
        phy_word = 16'h4400;
        for (int i = 1; i <= 5; i++) begin
            wait_done(upd);
            check("m100_link_up", 32'(link_up), (i >= 3) ? 1 : 0);
            check("m100_speed",   32'(speed),   (i >= 3) ? 1 : 2);
            check("m100_update",  32'(upd),     (i == 3) ? 1 : 0);
        end

        // No PHY: bus stays high.
        phy_present = 1'b0;
        wait_done(upd);
        check("nophy_error",   32'(error),   1);
        check("nophy_status",  32'(status),  16'hFFFF);
        check("nophy_link_up", 32'(link_up), 0);
        check("nophy_speed",   32'(speed),   1);
        check("nophy_update",  32'(upd),     1);

        // PHY back with speed field 11, which maps to 1000M.
        phy_present = 1'b1;
        phy_word    = 16'hC400;
        wait_done(upd);
        check("back_error",   32'(error),   0);
        check("back_link_up", 32'(link_up), 0);
        wait_done(upd);
        wait_done(upd);
        check("s11_link_up", 32'(link_up), 1);
        check("s11_speed",   32'(speed),   2);
        check("s11_update",  32'(upd),     1);

        // Asynchronous reset in the middle of DATA.
        n = 0;
        while (busy !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("mid_start_in_time", 32'(n < LIMIT), 1);
        repeat (400) @(negedge clk);
        check("mid_in_data_busy",   32'(busy),   1);
        check("mid_in_data_mdio_t", 32'(mdio_t), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_mdc",     32'(mdc),     0);
        check("arst_mdio_o",  32'(mdio_o),  1);
        check("arst_mdio_t",  32'(mdio_t),  0);
        check("arst_speed",   32'(speed),   2);
        check("arst_link_up", 32'(link_up), 0);
        check("arst_status",  32'(status),  0);
        check("arst_error",   32'(error),   0);
        check("arst_update",  32'(update),  0);
        check("arst_busy",    32'(busy),    0);
        @(negedge clk);
        rst = 1'b0;

        // Drop enable mid-frame: the frame finishes, then the block stays idle.
        n = 0;
        while (busy !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_start_in_time", 32'(n < LIMIT), 1);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        wait_done(upd);
        check("en_off_status",  32'(status),  16'hC400);
        check("en_off_link_up", 32'(link_up), 0);
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("en_off_idle", 32'(busy_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
